// File: rtl/fpu_ss_pkg.sv
// rtl/fpu_ss_pkg.sv - X interface types plus offloader table entry and FSM encoding
package fpu_ss_pkg;

  localparam int XIF_ID_WIDTH = 4;
  localparam int XIF_NUM_RS   = 3;

  typedef struct packed {
    logic [31:0]                       instr;
    logic [1:0]                        mode;
    logic [XIF_ID_WIDTH-1:0]           id;
    logic [XIF_NUM_RS-1:0][31:0]       rs;
    logic [XIF_NUM_RS-1:0]             rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
  } x_issue_resp_t;

  typedef struct packed {
    logic [XIF_ID_WIDTH-1:0] id;
    logic                    commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [XIF_ID_WIDTH-1:0] id;
    logic [31:0]             data;
    logic [4:0]              rd;
    logic                    we;
    logic                    exc;
  } x_result_t;

  typedef struct packed {
    logic                    valid;
    logic [XIF_ID_WIDTH-1:0] id;
    logic [4:0]              rd;
    logic                    writeback;
  } offload_entry_t;

  typedef enum logic [1:0] {
    OFFLOAD_IDLE   = 2'd0,
    OFFLOAD_ISSUE  = 2'd1,
    OFFLOAD_COMMIT = 2'd2
  } offload_fsm_e;

endpackage

// File: rtl/fpu_ss_offload_table.sv
// rtl/fpu_ss_offload_table.sv - outstanding offload tracking: alloc, free by ID, CAM lookup, rd_busy
module fpu_ss_offload_table
  import fpu_ss_pkg::*;
#(
  parameter int NUM_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    alloc,
  input  logic [XIF_ID_WIDTH-1:0] alloc_id,
  input  logic [4:0]              alloc_rd,
  input  logic                    alloc_writeback,
  input  logic                    kill_free,
  input  logic [XIF_ID_WIDTH-1:0] kill_id,
  input  logic                    lookup,
  input  logic [XIF_ID_WIDTH-1:0] lookup_id,
  output logic                    lookup_hit,
  output logic                    lookup_writeback,
  output logic                    full,
  output logic [31:0]             rd_busy
);

  localparam int CNT_W = $clog2(NUM_OUTSTANDING + 1);

  offload_entry_t               entries [NUM_OUTSTANDING];
  logic [NUM_OUTSTANDING-1:0]   hit_vec;
  logic [NUM_OUTSTANDING-1:0]   kill_vec;
  logic [NUM_OUTSTANDING-1:0]   wb_vec;
  logic [NUM_OUTSTANDING-1:0]   alloc_sel;
  logic [CNT_W-1:0]             count;
  logic                         found;
  logic                         alloc_do;
  logic                         res_free;
  logic                         kill_hit;

  always_comb begin
    hit_vec   = '0;
    kill_vec  = '0;
    wb_vec    = '0;
    alloc_sel = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_OUTSTANDING; i++) begin
      hit_vec[i]  = entries[i].valid && (entries[i].id == lookup_id);
      kill_vec[i] = entries[i].valid && (entries[i].id == kill_id);
      wb_vec[i]   = entries[i].writeback;
      if (!entries[i].valid && !found) begin
        alloc_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign lookup_hit       = |hit_vec;
  assign lookup_writeback = |(hit_vec & wb_vec);
  assign alloc_do         = alloc && found;
  assign res_free         = lookup && lookup_hit;
  assign kill_hit         = kill_free && (|kill_vec);
  assign full             = (count >= CNT_W'(NUM_OUTSTANDING));

  // Live IDs are unique, so a result-free and a kill-free never hit the same slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_OUTSTANDING; i++) entries[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < NUM_OUTSTANDING; i++) begin
        if (alloc_do && alloc_sel[i]) begin
          entries[i] <= '{valid: 1'b1, id: alloc_id, rd: alloc_rd, writeback: alloc_writeback};
        end else if ((lookup && hit_vec[i]) || (kill_free && kill_vec[i])) begin
          entries[i].valid <= 1'b0;
        end
      end
      count <= count + CNT_W'(alloc_do) - CNT_W'(res_free) - CNT_W'(kill_hit);
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NUM_OUTSTANDING; i++) begin
      if (entries[i].valid && entries[i].writeback) rd_busy[entries[i].rd] = 1'b1;
    end
    rd_busy[0] = 1'b0;
  end

endmodule

// File: rtl/fpu_ss_xif_offloader.sv
// rtl/fpu_ss_xif_offloader.sv - core-side X interface initiator: issue, commit, result writeback
module fpu_ss_xif_offloader
  import fpu_ss_pkg::*;
#(
  parameter int X_ID_WIDTH      = XIF_ID_WIDTH,
  parameter int NUM_OUTSTANDING = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             off_valid_i,
  output logic             off_ready_o,
  input  logic [31:0]      off_instr_i,
  input  logic [2:0][31:0] off_rs_i,
  input  logic [2:0]       off_rs_valid_i,
  input  logic [1:0]       off_mode_i,
  input  logic             off_kill_i,
  output logic             off_accept_o,
  output logic             off_illegal_o,
  output logic [31:0]      rd_busy_o,
  output logic             x_issue_valid_o,
  input  logic             x_issue_ready_i,
  output x_issue_req_t     x_issue_req_o,
  input  x_issue_resp_t    x_issue_resp_i,
  output logic             x_commit_valid_o,
  output x_commit_t        x_commit_o,
  input  logic             x_result_valid_i,
  output logic             x_result_ready_o,
  input  x_result_t        x_result_i,
  output logic             wb_we_o,
  output logic [4:0]       wb_rd_o,
  output logic [31:0]      wb_data_o,
  output logic             wb_exc_o,
  input  logic             wb_ready_i,
  output logic             err_unknown_id_o
);

  localparam logic [1:0] IDLE   = OFFLOAD_IDLE;
  localparam logic [1:0] ISSUE  = OFFLOAD_ISSUE;
  localparam logic [1:0] COMMIT = OFFLOAD_COMMIT;

  logic [1:0]            state;
  logic [X_ID_WIDTH-1:0] id_cnt;
  x_issue_req_t          req_q;
  logic                  kill_q;
  logic                  accept_q;
  logic                  issue_hs;
  logic                  result_hs;
  logic                  commit_kill;
  logic                  table_full;
  logic                  lookup_hit;
  logic                  lookup_writeback;

  assign issue_hs    = (state == ISSUE) && x_issue_ready_i;
  assign result_hs   = x_result_valid_i && wb_ready_i;
  assign commit_kill = kill_q || off_kill_i || !accept_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      id_cnt   <= '0;
      req_q    <= '0;
      kill_q   <= 1'b0;
      accept_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (off_valid_i && off_ready_o) begin
            req_q.instr    <= off_instr_i;
            req_q.rs       <= off_rs_i;
            req_q.rs_valid <= off_rs_valid_i;
            req_q.mode     <= off_mode_i;
            req_q.id       <= id_cnt;
            kill_q         <= 1'b0;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (off_kill_i) kill_q <= 1'b1;
          if (x_issue_ready_i) begin
            id_cnt   <= id_cnt + 1'b1;
            accept_q <= x_issue_resp_i.accept;
            state    <= COMMIT;
          end
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign off_ready_o    = (state == IDLE) && !table_full;
  assign x_issue_valid_o = (state == ISSUE);
  assign x_issue_req_o   = req_q;
  assign off_accept_o    = issue_hs && x_issue_resp_i.accept;
  assign off_illegal_o   = issue_hs && !x_issue_resp_i.accept;

  assign x_commit_valid_o       = (state == COMMIT);
  assign x_commit_o.id          = req_q.id;
  assign x_commit_o.commit_kill = commit_kill;

  // Writeback is gated on the entry recorded at issue, not only on the result's own we
  assign x_result_ready_o = wb_ready_i;
  assign wb_we_o          = result_hs && lookup_hit && lookup_writeback && x_result_i.we
                            && (x_result_i.rd != 5'd0);
  assign wb_rd_o          = x_result_i.rd;
  assign wb_data_o        = x_result_i.data;
  assign wb_exc_o         = x_result_i.exc;
  assign err_unknown_id_o = result_hs && !lookup_hit;

  fpu_ss_offload_table #(
    .NUM_OUTSTANDING(NUM_OUTSTANDING)
  ) u_table (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .alloc           (issue_hs && x_issue_resp_i.accept),
    .alloc_id        (req_q.id),
    .alloc_rd        (req_q.instr[11:7]),
    .alloc_writeback (x_issue_resp_i.writeback),
    .kill_free       ((state == COMMIT) && commit_kill && accept_q),
    .kill_id         (req_q.id),
    .lookup          (result_hs),
    .lookup_id       (x_result_i.id),
    .lookup_hit      (lookup_hit),
    .lookup_writeback(lookup_writeback),
    .full            (table_full),
    .rd_busy         (rd_busy_o)
  );

endmodule
